// File: rtl/pri_enc_pkg.sv
// Shared types and constants for the sequential priority encoder.
package pri_enc_pkg;

    // Controller states: waiting for a vector, or emitting its index beats.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Selection policy latched with each accepted vector.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : pri_enc_pkg

// File: rtl/pri_enc_pick.sv
// Combinational wrap-around pick: scans downward from a start position and
// returns the first set bit. Fixed mode always starts at the MSB; round-robin
// starts just below the pointer, and a pointer of 0 starts at the MSB so the
// first search after reset matches fixed mode.
module pri_enc_pick
    import pri_enc_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int IDXW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDXW-1:0]  ptr,
    input  logic             mode,
    output logic [IDXW-1:0]  idx,
    output logic             found
);

    // Downward scan with wrap from 0 back to WIDTH-1; the first hit wins.
    always_comb begin : pick_search
        int start_v;
        int pos_v;
        logic [IDXW-1:0] pos_s;
        idx     = '0;
        found   = 1'b0;
        start_v = WIDTH - 1;
        pos_v   = 0;
        pos_s   = '0;
        if ((mode == MODE_RR) && (ptr != '0) && (int'(ptr) <= WIDTH)) begin
            start_v = int'(ptr) - 1;
        end else begin
            start_v = WIDTH - 1;
        end
        for (int k = 0; k < WIDTH; k++) begin
            pos_v = start_v - k;
            if (pos_v < 0) begin
                pos_v = pos_v + WIDTH;
            end else begin
                pos_v = pos_v;
            end
            pos_s = IDXW'(pos_v);
            if (!found && vec[pos_s]) begin
                found = 1'b1;
                idx   = pos_s;
            end else begin
                found = found;
            end
        end
    end

endmodule : pri_enc_pick

// File: rtl/pri_enc_seq.sv
// Sequential priority encoder: accepts a request vector, then streams the
// index of every set bit as one beat each, in fixed MSB-first or round-robin
// order. Output fields are registered; the pick runs on next-state values so
// a beat appears one cycle after acceptance and stays stable under stall.
module pri_enc_seq
    import pri_enc_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int IDXW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_none,
    output logic             out_last,
    output logic             busy
);

    state_t            state_r;
    state_t            state_nx;
    logic [WIDTH-1:0]  pending_r;
    logic [WIDTH-1:0]  pending_nx;
    logic [IDXW-1:0]   rr_ptr_r;
    logic [IDXW-1:0]   rr_ptr_nx;
    logic              mode_r;
    logic              mode_nx;

    logic              out_valid_r;
    logic              out_valid_nx;
    logic [IDXW-1:0]   out_idx_r;
    logic [IDXW-1:0]   out_idx_nx;
    logic              out_none_r;
    logic              out_none_nx;
    logic              out_last_r;
    logic              out_last_nx;

    logic              accept_s;
    logic              beat_s;
    logic [WIDTH-1:0]  clear_mask_s;
    logic [IDXW-1:0]   pick_idx_s;
    logic              pick_found_s;

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign out_none  = out_none_r;
    assign out_last  = out_last_r;

    // flush wins over a simultaneous offer, so no vector is taken that cycle.
    assign accept_s     = in_valid && in_ready && !flush;
    assign beat_s       = out_valid_r && out_ready;
    assign clear_mask_s = ~(WIDTH'(1) << out_idx_r);

    // Next-state logic: acceptance, beat retirement, pointer update, flush.
    always_comb begin
        state_nx   = state_r;
        pending_nx = pending_r;
        rr_ptr_nx  = rr_ptr_r;
        mode_nx    = mode_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    pending_nx = in_vec;
                    mode_nx    = mode;
                    state_nx   = EMIT;
                end else begin
                    state_nx   = IDLE;
                end
            end
            EMIT: begin
                if (beat_s) begin
                    pending_nx = pending_r & clear_mask_s;
                    if (mode_r == MODE_RR) begin
                        rr_ptr_nx = out_idx_r;
                    end else begin
                        rr_ptr_nx = rr_ptr_r;
                    end
                    if (out_last_r) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = EMIT;
                    end
                end else begin
                    state_nx = EMIT;
                end
                // A beat handshaken alongside flush still counts as delivered.
                if (flush) begin
                    state_nx   = IDLE;
                    pending_nx = '0;
                end else begin
                    state_nx   = state_nx;
                end
            end
            default: begin
                state_nx   = IDLE;
                pending_nx = '0;
            end
        endcase
    end

    pri_enc_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .vec   (pending_nx),
        .ptr   (rr_ptr_nx),
        .mode  (mode_nx),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Output beat for the upcoming cycle, derived from the next-state pending set.
    always_comb begin
        out_valid_nx = 1'b0;
        out_idx_nx   = '0;
        out_none_nx  = 1'b0;
        out_last_nx  = 1'b0;
        if (state_nx == EMIT) begin
            out_valid_nx = 1'b1;
            out_none_nx  = !pick_found_s;
            out_idx_nx   = pick_found_s ? pick_idx_s : '0;
            out_last_nx  = ((pending_nx & (pending_nx - WIDTH'(1))) == '0);
        end else begin
            out_valid_nx = 1'b0;
        end
    end

    // Controller state, pending set, pointer and latched mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            pending_r <= '0;
            rr_ptr_r  <= '0;
            mode_r    <= MODE_FIXED;
        end else begin
            state_r   <= state_nx;
            pending_r <= pending_nx;
            rr_ptr_r  <= rr_ptr_nx;
            mode_r    <= mode_nx;
        end
    end

    // Registered output beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_idx_r   <= '0;
            out_none_r  <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_nx;
            out_idx_r   <= out_idx_nx;
            out_none_r  <= out_none_nx;
            out_last_r  <= out_last_nx;
        end
    end

endmodule : pri_enc_seq

// File: tb/tb_pri_enc_seq.sv
// Self-checking bench for pri_enc_seq (WIDTH = 16): directed scenarios plus
// randomized vectors checked against a set-based reference model.
module tb_pri_enc_seq;

    localparam int WIDTH = 16;
    localparam int IDXW  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec = '0;
    logic             mode = 1'b0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [IDXW-1:0]  out_idx;
    logic             out_none;
    logic             out_last;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    int obs_idx[$];
    bit obs_none[$];
    bit obs_last[$];
    int exp_idx[$];
    bit exp_none[$];
    bit exp_last[$];
    bit timed_out;
    bit unstable;
    bit first_valid;
    int model_rr = 0;

    pri_enc_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .mode      (mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: every set bit is emitted once; each pick is the first set bit
    // scanning downward (with wrap) from the start point the policy dictates.
    function automatic void model_beats(input logic [15:0] v, input bit m);
        bit rem[16];
        int left = 0;
        exp_idx.delete(); exp_none.delete(); exp_last.delete();
        for (int i = 0; i < 16; i++) begin
            rem[i] = v[i];
            left += int'(v[i]);
        end
        if (left == 0) begin
            exp_idx.push_back(0); exp_none.push_back(1'b1); exp_last.push_back(1'b1);
            if (m) model_rr = 0;
            return;
        end
        while (left > 0) begin
            int start = (m && model_rr != 0) ? model_rr - 1 : 15;
            int p = -1;
            for (int k = 0; k < 16; k++) begin
                int q = (start - k + 16) % 16;
                if (p < 0 && rem[q]) p = q;
            end
            rem[p] = 1'b0;
            left--;
            exp_idx.push_back(p); exp_none.push_back(1'b0); exp_last.push_back(left == 0);
            if (m) model_rr = p;
        end
    endfunction

    task automatic accept_vec(input logic [15:0] v, input bit m);
        in_vec = v; mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_vec = 16'(~v); mode = ~m;
    endtask

    // Gathers beats until the last one is handshaken or the budget runs out.
    task automatic collect(input int ready_pct, input int budget);
        bit held = 1'b0;
        int pi = 0;
        bit pn = 1'b0;
        bit pl = 1'b0;
        obs_idx.delete(); obs_none.delete(); obs_last.delete();
        timed_out = 1'b1; unstable = 1'b0; first_valid = 1'b0;
        for (int c = 0; c < budget; c++) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            @(negedge clk);
            if (c == 0) first_valid = out_valid;
            if (out_valid) begin
                if (held && (int'(out_idx) != pi || out_none != pn || out_last != pl)) unstable = 1'b1;
                if (out_ready) begin
                    obs_idx.push_back(int'(out_idx)); obs_none.push_back(out_none); obs_last.push_back(out_last);
                    held = 1'b0;
                    if (out_last) begin
                        timed_out = 1'b0;
                        @(posedge clk); #1;
                        out_ready = 1'b0;
                        break;
                    end
                end else begin
                    held = 1'b1; pi = int'(out_idx); pn = out_none; pl = out_last;
                end
            end else begin
                held = 1'b0;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        model_rr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_valid_busy: got %0b/%0b want 0/0", out_valid, busy); end
        n_vec++; if (out_idx !== 4'd0 || out_none !== 1'b0 || out_last !== 1'b0) begin
            n_err++; $display("FAIL reset_fields: got idx=%0d none=%0b last=%0b want 0/0/0", out_idx, out_none, out_last);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_fixed();
        accept_vec(16'h8001, 1'b0);
        collect(100, 20);
        exp_idx.delete(); exp_none.delete(); exp_last.delete();
        exp_idx.push_back(15); exp_none.push_back(1'b0); exp_last.push_back(1'b0);
        exp_idx.push_back(0);  exp_none.push_back(1'b0); exp_last.push_back(1'b1);
        n_vec++; if (first_valid !== 1'b1) begin n_err++; $display("FAIL fixed_latency: got valid=%0b want 1", first_valid); end
        n_vec++; if (timed_out || obs_idx.size() != exp_idx.size()) begin
            n_err++; $display("FAIL fixed_count: got %0d beats (timeout=%0b) want %0d", obs_idx.size(), timed_out, exp_idx.size());
        end else begin
            for (int k = 0; k < exp_idx.size(); k++) begin
                n_vec++;
                if (obs_idx[k] != exp_idx[k] || obs_none[k] != exp_none[k] || obs_last[k] != exp_last[k]) begin
                    n_err++; $display("FAIL fixed_beat%0d: got idx=%0d none=%0b last=%0b want idx=%0d none=%0b last=%0b",
                        k, obs_idx[k], obs_none[k], obs_last[k], exp_idx[k], exp_none[k], exp_last[k]);
                end
            end
        end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fixed_ready_after: got %0b want 1", in_ready); end
    endtask

    task automatic test_empty();
        accept_vec(16'h0000, 1'b0);
        collect(100, 20);
        n_vec++; if (timed_out || obs_idx.size() != 1) begin
            n_err++; $display("FAIL empty_count: got %0d beats (timeout=%0b) want 1", obs_idx.size(), timed_out);
        end else begin
            n_vec++;
            if (obs_idx[0] != 0 || obs_none[0] != 1'b1 || obs_last[0] != 1'b1) begin
                n_err++; $display("FAIL empty_beat: got idx=%0d none=%0b last=%0b want 0/1/1", obs_idx[0], obs_none[0], obs_last[0]);
            end
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL empty_idle: got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
    endtask

    // After reset: 0x0010 rr -> 4; 0x0021 rr -> 0 then 5; then a mode-0
    // vector must leave the pointer at 5 so 0x0041 rr yields 0 then 6.
    task automatic test_rr_wrap();
        int want[8] = '{4, 0, 5, 6, 0, 0, 6, -1};
        bit wlast[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] vecs[4] = '{16'h0010, 16'h0021, 16'h0041, 16'h0041};
        bit modes[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int nb[4] = '{1, 2, 2, 2};
        int base = 0;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            accept_vec(vecs[t], modes[t]);
            collect(100, 20);
            n_vec++; if (timed_out || obs_idx.size() != nb[t]) begin
                n_err++; $display("FAIL rr_count%0d: got %0d beats (timeout=%0b) want %0d", t, obs_idx.size(), timed_out, nb[t]);
            end else begin
                for (int k = 0; k < nb[t]; k++) begin
                    n_vec++;
                    if (obs_idx[k] != want[base+k] || obs_last[k] != wlast[base+k] || obs_none[k] != 1'b0) begin
                        n_err++; $display("FAIL rr_beat%0d_%0d: got idx=%0d last=%0b want idx=%0d last=%0b",
                            t, k, obs_idx[k], obs_last[k], want[base+k], wlast[base+k]);
                    end
                end
            end
            base += nb[t];
        end
    endtask

    task automatic test_backpressure();
        accept_vec(16'h0300, 1'b0);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== 4'd9 || out_last !== 1'b0 || out_none !== 1'b0) begin
                n_err++; $display("FAIL bp_hold%0d: got valid=%0b idx=%0d last=%0b want 1/9/0", c, out_valid, out_idx, out_last);
            end
            @(posedge clk); #1;
        end
        collect(100, 20);
        n_vec++; if (timed_out || obs_idx.size() != 2) begin
            n_err++; $display("FAIL bp_count: got %0d beats (timeout=%0b) want 2", obs_idx.size(), timed_out);
        end else begin
            n_vec++; if (obs_idx[0] != 9 || obs_last[0] != 1'b0 || obs_idx[1] != 8 || obs_last[1] != 1'b1) begin
                n_err++; $display("FAIL bp_order: got %0d/%0b,%0d/%0b want 9/0,8/1", obs_idx[0], obs_last[0], obs_idx[1], obs_last[1]);
            end
        end
    endtask

    task automatic test_flush();
        accept_vec(16'hFFFF, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_idx !== 4'd15) begin
            n_err++; $display("FAIL flush_beat1: got valid=%0b idx=%0d want 1/15", out_valid, out_idx);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_idx !== 4'd14) begin
            n_err++; $display("FAIL flush_beat2: got valid=%0b idx=%0d want 1/14", out_valid, out_idx);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                n_err++; $display("FAIL flush_idle%0d: got valid=%0b ready=%0b busy=%0b want 0/1/0", c, out_valid, in_ready, busy);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    // flush alongside an offer in IDLE: the offer is not taken.
    task automatic test_flush_idle();
        flush = 1'b1; in_valid = 1'b1; in_vec = 16'h0004; mode = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_precedence: got valid=%0b busy=%0b ready=%0b want 0/0/1", out_valid, busy, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        accept_vec(16'h0002, 1'b1);
        collect(100, 20);
        accept_vec(16'h00F0, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_async: got valid=%0b busy=%0b ready=%0b want 0/0/1", out_valid, busy, in_ready);
        end
        #1 rst = 1'b0;
        accept_vec(16'h0003, 1'b1);
        collect(100, 20);
        n_vec++; if (timed_out || obs_idx.size() != 2) begin
            n_err++; $display("FAIL rst_count: got %0d beats (timeout=%0b) want 2", obs_idx.size(), timed_out);
        end else begin
            n_vec++; if (obs_idx[0] != 1 || obs_last[0] != 1'b0 || obs_idx[1] != 0 || obs_last[1] != 1'b1) begin
                n_err++; $display("FAIL rst_order: got %0d/%0b,%0d/%0b want 1/0,0/1", obs_idx[0], obs_last[0], obs_idx[1], obs_last[1]);
            end
        end
    endtask

    // Back-to-back random vectors with random backpressure against the model.
    task automatic test_random();
        do_reset();
        for (int t = 0; t < 40; t++) begin
            logic [15:0] v;
            bit m;
            int sel = $urandom_range(0, 3);
            v = 16'($urandom);
            if (sel == 0) v = 16'($urandom & $urandom & $urandom);
            if (sel == 1 && $urandom_range(0, 3) == 0) v = 16'h0000;
            m = 1'($urandom_range(0, 1));
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rnd_ready%0d: got %0b want 1", t, in_ready); end
            accept_vec(v, m);
            model_beats(v, m);
            collect($urandom_range(30, 100), 400);
            n_vec++; if (first_valid !== 1'b1 || unstable !== 1'b0) begin
                n_err++; $display("FAIL rnd_timing%0d: got first_valid=%0b unstable=%0b want 1/0", t, first_valid, unstable);
            end
            n_vec++; if (timed_out || obs_idx.size() != exp_idx.size()) begin
                n_err++; $display("FAIL rnd_count%0d: vec=%h mode=%0b got %0d beats (timeout=%0b) want %0d",
                    t, v, m, obs_idx.size(), timed_out, exp_idx.size());
            end else begin
                for (int k = 0; k < exp_idx.size(); k++) begin
                    n_vec++;
                    if (obs_idx[k] != exp_idx[k] || obs_none[k] != exp_none[k] || obs_last[k] != exp_last[k]) begin
                        n_err++; $display("FAIL rnd_beat%0d_%0d: vec=%h mode=%0b got idx=%0d none=%0b last=%0b want idx=%0d none=%0b last=%0b",
                            t, k, v, m, obs_idx[k], obs_none[k], obs_last[k], exp_idx[k], exp_none[k], exp_last[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_empty();
        test_rr_wrap();
        test_backpressure();
        test_flush();
        test_flush_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pri_enc_seq

// File: doc/pri_enc_seq.md
PRI_ENC_SEQ -- requirements
Module: pri_enc_seq

Interface
REQ-001 Parameter WIDTH, default 16: number of request bits; legal range 2..256.
REQ-002 Derived constant IDXW, equal to $clog2(WIDTH): width of the index output.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  the source offers a request vector.
REQ-006 in_ready  output  1  the block can accept a vector; high only in IDLE.
REQ-007 in_vec  input  WIDTH  request bits; bit WIDTH-1 is the highest fixed priority.
REQ-008 mode  input  1  0 = fixed MSB-first; 1 = round-robin; sampled at acceptance only.
REQ-009 flush  input  1  synchronous abort of the vector in progress.
REQ-010 out_valid  output  1  an index beat is presented.
REQ-011 out_ready  input  1  the sink accepts the beat.
REQ-012 out_idx  output  IDXW  index of the selected request bit.
REQ-013 out_none  output  1  the accepted vector was all-zero; out_idx is 0.
REQ-014 out_last  output  1  final beat of the current vector.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have two states: IDLE and EMIT.
REQ-017 in_valid && in_ready SHALL load pending <= in_vec, latch mode, and move the FSM to EMIT.
REQ-018 out_valid SHALL rise exactly one cycle after acceptance; there is no combinational path from in_vec to any output.
REQ-019 In EMIT, out_valid SHALL be 1.
REQ-020 In EMIT, out_idx SHALL be the pick from the pending register:
- mode 0: the highest set bit;
- mode 1: the first set bit searching downward from rr_ptr-1, wrapping from 0 to WIDTH-1.
REQ-021 out_last SHALL equal 1 when pending has at most one set bit.
REQ-022 On out_valid && out_ready, the block SHALL clear pending[out_idx].
REQ-023 On out_valid && out_ready in mode 1, the block SHALL set rr_ptr <= out_idx.
REQ-024 On out_valid && out_ready with out_last = 1, the FSM SHALL return to IDLE, with in_ready = 1 in the next cycle.
REQ-025 rr_ptr SHALL persist across vectors and SHALL NOT be updated while in mode 0.
REQ-026 An all-zero vector SHALL produce exactly one beat with out_none = 1, out_last = 1 and out_idx = 0.
REQ-027 While out_valid = 1 and out_ready = 0, out_idx, out_none and out_last SHALL hold stable.
REQ-028 A vector of N set bits SHALL produce exactly N beats, each index once; max throughput is one beat per cycle.
REQ-029 flush in EMIT SHALL force IDLE next cycle, clear pending, and drop out_valid.
REQ-030 flush in the same cycle as a beat handshake SHALL count that beat as delivered; no further beats follow.
REQ-031 flush in IDLE SHALL have no effect.
REQ-032 flush SHALL take precedence over in_valid in the same cycle.
REQ-033 In IDLE, out_valid, out_idx, out_none and out_last SHALL be 0.

Reset
REQ-034 Asserting rst SHALL immediately set: state to IDLE, pending to 0, rr_ptr to 0, out_valid to 0, out_idx to 0, out_none to 0, out_last to 0, busy to 0.
REQ-035 In-flight beats SHALL be lost on reset.
REQ-036 in_ready SHALL be 1 while rst is high and after its release.
REQ-037 With rr_ptr = 0 after reset, the first mode-1 search SHALL start at WIDTH-1, so it matches mode 0.

Structure
REQ-038 Package pri_enc_pkg SHALL hold the state enum (IDLE, EMIT) and the mode constants (MODE_FIXED = 0, MODE_RR = 1).
REQ-039 One combinational sub-module pri_enc_pick SHALL implement the wrap-around masked pick from (vector, start pointer, mode) to (idx, found).
REQ-040 pri_enc_pick SHALL be parametrised by WIDTH.

Verification (WIDTH = 16)
REQ-041 Fixed order: in_vec = 0x8001, mode 0, out_ready = 1 -> beats idx 15 (last = 0), then idx 0 (last = 1); in_ready = 1 on the following cycle.
REQ-042 Empty vector: in_vec = 0x0000 -> a single beat with out_none = 1, out_last = 1, out_idx = 0.
REQ-043 Round-robin wrap: after reset send 0x0010, mode 1 -> idx 4; then send 0x0021, mode 1 -> idx 0, then idx 5 (last = 1).
REQ-044 Backpressure: in_vec = 0x0300 with out_ready low for 3 cycles -> out_idx = 9 and out_last = 0 stay stable; after release, idx 9 then idx 8.
REQ-045 Flush: in_vec = 0xFFFF with flush asserted after the 2nd beat handshake -> out_valid = 0 and in_ready = 1 next cycle; only idx 15 and idx 14 are seen.
REQ-046 Reset mid-EMIT: rst asserted asynchronously -> out_valid = 0 and busy = 0 before the next clock edge; the next mode-1 vector 0x0003 yields idx 1, then idx 0.
